// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types and helpers.
// Memory-op encoding and access-size decode used by the LSU.
package riscv_pkg;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LW   = 4'd3,
        MEM_LBU  = 4'd4,
        MEM_LHU  = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } mem_size_t;

    function automatic logic is_load(mem_op_t op);
        return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
    endfunction

    function automatic logic is_store(mem_op_t op);
        return op inside {MEM_SB, MEM_SH, MEM_SW};
    endfunction

    function automatic mem_size_t mem_size(mem_op_t op);
        mem_size_t sz;
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: sz = SZ_B;
            MEM_LH, MEM_LHU, MEM_SH: sz = SZ_H;
            default:                 sz = SZ_W;
        endcase
        return sz;
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic is_misaligned(mem_op_t op, logic [1:0] off);
        logic bad;
        bad = 1'b0;
        if (is_load(op) || is_store(op)) begin
            case (mem_size(op))
                SZ_H:    bad = off[0];
                SZ_W:    bad = |off;
                default: bad = 1'b0;
            endcase
        end
        return bad;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane extraction and sign/zero extension.
// Pure combinational; selects the byte/half lane given by off.
module lsu_load_align
    import riscv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  mem_op_t     op,
    output logic [31:0] data
);

    logic [31:0] lane;

    assign lane = rdata >> {off, 3'b000};

    // Pick extension by load type; words pass through untouched.
    always_comb begin
        data = rdata;
        unique case (1'b1)
            (op == MEM_LB):  data = {{24{lane[7]}}, lane[7:0]};
            (op == MEM_LBU): data = {24'd0, lane[7:0]};
            (op == MEM_LH):  data = {{16{lane[15]}}, lane[15:0]};
            (op == MEM_LHU): data = {16'd0, lane[15:0]};
            default:         data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// MEM-stage load/store unit with req/gnt/rvalid data port.
// Unpipelined memory ops; MEM_NONE passes straight through.
module lsu
    import riscv_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  mem_op_t               ex_mem_op,
    input  logic [31:0]           ex_addr,
    input  logic [31:0]           ex_store_data,
    input  logic [4:0]            ex_rd,
    input  logic                  flush,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [31:0]           dmem_wdata,
    input  logic                  dmem_gnt,
    input  logic                  dmem_rvalid,
    input  logic [31:0]           dmem_rdata,
    output logic                  wb_valid,
    output logic                  wb_we,
    output logic [4:0]            wb_rd,
    output logic [31:0]           wb_data,
    output logic                  misaligned
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} lsu_state_t;

    lsu_state_t state, state_d;

    mem_op_t    op_q;
    logic [4:0] rd_q;
    logic [1:0] off_q;

    logic        accept, ex_mem, ex_mis, go;
    logic [31:0] wd_f, ld_data;
    logic [3:0]  be_f;

    logic                  req_d, we_d, wbv_d, wbwe_d, mis_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [3:0]            be_d;
    logic [31:0]           wd_d, wbdata_d;
    logic [4:0]            wbrd_d;

    assign ex_ready = (state == IDLE);
    assign accept   = ex_valid && ex_ready && !flush;
    assign ex_mem   = is_load(ex_mem_op) || is_store(ex_mem_op);
    assign ex_mis   = is_misaligned(ex_mem_op, ex_addr[1:0]);
    assign go       = accept && ex_mem && !ex_mis;

    lsu_load_align u_align (
        .rdata (dmem_rdata),
        .off   (off_q),
        .op    (op_q),
        .data  (ld_data)
    );

    // Lane-replicate store data and place byte enables at the offset.
    always_comb begin
        wd_f = ex_store_data;
        be_f = 4'b1111;
        if (is_store(ex_mem_op)) begin
            case (mem_size(ex_mem_op))
                SZ_B: begin
                    wd_f = {4{ex_store_data[7:0]}};
                    be_f = 4'b0001 << ex_addr[1:0];
                end
                SZ_H: begin
                    wd_f = {2{ex_store_data[15:0]}};
                    be_f = 4'b0011 << ex_addr[1:0];
                end
                default: begin
                    wd_f = ex_store_data;
                    be_f = 4'b1111;
                end
            endcase
        end
    end

    // State and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_q       <= MEM_NONE;
            rd_q       <= 5'd0;
            off_q      <= 2'd0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= 4'd0;
            dmem_wdata <= 32'd0;
            wb_valid   <= 1'b0;
            wb_we      <= 1'b0;
            wb_rd      <= 5'd0;
            wb_data    <= 32'd0;
            misaligned <= 1'b0;
        end else begin
            state      <= state_d;
            if (accept) begin
                op_q  <= ex_mem_op;
                rd_q  <= ex_rd;
                off_q <= ex_addr[1:0];
            end
            dmem_req   <= req_d;
            dmem_we    <= we_d;
            dmem_addr  <= addr_d;
            dmem_be    <= be_d;
            dmem_wdata <= wd_d;
            wb_valid   <= wbv_d;
            wb_we      <= wbwe_d;
            wb_rd      <= wbrd_d;
            wb_data    <= wbdata_d;
            misaligned <= mis_d;
        end
    end

    // Next state; a flush racing rvalid in WAIT has nothing left to drain.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:  if (go) state_d = REQ;
            REQ: begin
                if (dmem_gnt) begin
                    if (is_store(op_q)) state_d = IDLE;
                    else if (flush)     state_d = DRAIN;
                    else                state_d = WAIT;
                end else if (flush) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (dmem_rvalid)  state_d = IDLE;
                else if (flush)   state_d = DRAIN;
            end
            DRAIN: if (dmem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        req_d    = 1'b0;
        we_d     = dmem_we;
        addr_d   = dmem_addr;
        be_d     = dmem_be;
        wd_d     = dmem_wdata;
        wbv_d    = 1'b0;
        wbwe_d   = 1'b0;
        wbrd_d   = wb_rd;
        wbdata_d = wb_data;
        mis_d    = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    wbrd_d   = ex_rd;
                    wbdata_d = ex_addr;
                    if (go) begin
                        req_d  = 1'b1;
                        we_d   = is_store(ex_mem_op);
                        addr_d = {ex_addr[ADDR_WIDTH-1:2], 2'b00};
                        be_d   = be_f;
                        wd_d   = wd_f;
                    end else begin
                        wbv_d  = 1'b1;
                        wbwe_d = !ex_mem && (ex_rd != 5'd0);
                        mis_d  = ex_mis;
                    end
                end
            end
            REQ: begin
                req_d = !dmem_gnt && !flush;
                wbv_d = dmem_gnt && is_store(op_q) && !flush;
            end
            WAIT: begin
                if (dmem_rvalid && !flush) begin
                    wbv_d    = 1'b1;
                    wbwe_d   = (rd_q != 5'd0);
                    wbrd_d   = rd_q;
                    wbdata_d = ld_data;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for the lsu block.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_lsu;
    import riscv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    mem_op_t     ex_mem_op;
    logic [31:0] ex_addr;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        flush;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misaligned;

    int n_cmp = 0;
    int n_bad = 0;

    lsu #(.ADDR_WIDTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_mem_op     (ex_mem_op),
        .ex_addr       (ex_addr),
        .ex_store_data (ex_store_data),
        .ex_rd         (ex_rd),
        .flush         (flush),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_be       (dmem_be),
        .dmem_wdata    (dmem_wdata),
        .dmem_gnt      (dmem_gnt),
        .dmem_rvalid   (dmem_rvalid),
        .dmem_rdata    (dmem_rdata),
        .wb_valid      (wb_valid),
        .wb_we         (wb_we),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .misaligned    (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic issue(mem_op_t op, logic [31:0] a,
                         logic [31:0] d, logic [4:0] rd);
        ex_valid      = 1'b1;
        ex_mem_op     = op;
        ex_addr       = a;
        ex_store_data = d;
        ex_rd         = rd;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ex_valid = 1'b0; ex_mem_op = MEM_NONE; ex_addr = 0;
        ex_store_data = 0; ex_rd = 0; flush = 1'b0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 0;
        tick(); tick();
        n_cmp++;
        if ({dmem_req, dmem_we, wb_valid, wb_we, misaligned} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {dmem_req, dmem_we, wb_valid, wb_we, misaligned});
        end
        n_cmp++;
        if ({dmem_addr, dmem_be, dmem_wdata, wb_rd, wb_data} !== '0) begin
            n_bad++;
            $display("FAIL reset_data: addr %h be %b wd %h rd %0d d %h want 0",
                     dmem_addr, dmem_be, dmem_wdata, wb_rd, wb_data);
        end
        n_cmp++;
        if (ex_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: got %b want 1", ex_ready);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_none();
        issue(MEM_NONE, 32'h1234, 32'h0, 5'd5);
        tick();
        n_cmp++;
        if ({wb_valid, wb_we, wb_rd, wb_data, ex_ready} !==
            {1'b1, 1'b1, 5'd5, 32'h00001234, 1'b1}) begin
            n_bad++;
            $display("FAIL none_wb: v%b we%b rd%0d d%h rdy%b want 1 1 5 00001234 1",
                     wb_valid, wb_we, wb_rd, wb_data, ex_ready);
        end
        issue(MEM_NONE, 32'h55, 32'h0, 5'd0);
        tick();
        n_cmp++;
        if ({wb_valid, wb_we, wb_data} !== {1'b1, 1'b0, 32'h55}) begin
            n_bad++;
            $display("FAIL none_b2b_rd0: v%b we%b d%h want 1 0 00000055",
                     wb_valid, wb_we, wb_data);
        end
        ex_valid = 1'b0;
        tick();
        n_cmp++;
        if (wb_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL none_pulse: got %b want 0", wb_valid);
        end
    endtask

    task automatic test_store();
        issue(MEM_SB, 32'h103, 32'hAABBCCDD, 5'd1);
        tick();
        ex_valid = 1'b0;
        n_cmp++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, ex_ready} !==
            {1'b1, 1'b1, 32'h100, 4'b1000, 32'hDDDDDDDD, 1'b0}) begin
            n_bad++;
            $display("FAIL sb_req: req%b we%b a%h be%b wd%h rdy%b want 1 1 100 1000 DDDDDDDD 0",
                     dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, ex_ready);
        end
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        n_cmp++;
        if ({dmem_req, wb_valid, wb_we, ex_ready} !== 4'b0101) begin
            n_bad++;
            $display("FAIL sb_wb: req%b v%b we%b rdy%b want 0 1 0 1",
                     dmem_req, wb_valid, wb_we, ex_ready);
        end
        issue(MEM_SH, 32'h202, 32'h11223344, 5'd2);
        tick();
        ex_valid = 1'b0;
        tick();
        n_cmp++;
        if ({dmem_req, dmem_addr, dmem_be, dmem_wdata} !==
            {1'b1, 32'h200, 4'b1100, 32'h33443344}) begin
            n_bad++;
            $display("FAIL sh_hold: req%b a%h be%b wd%h want 1 200 1100 33443344",
                     dmem_req, dmem_addr, dmem_be, dmem_wdata);
        end
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        n_cmp++;
        if ({dmem_req, wb_valid, wb_we} !== 3'b010) begin
            n_bad++;
            $display("FAIL sh_wb: req%b v%b we%b want 0 1 0",
                     dmem_req, wb_valid, wb_we);
        end
    endtask

    task automatic test_load(mem_op_t op, logic [31:0] a, logic [31:0] rd_word,
                             logic [31:0] exp, int gw, int rw);
        issue(op, a, 32'h0, 5'd7);
        tick();
        ex_valid = 1'b0;
        n_cmp++;
        if ({dmem_req, dmem_we, dmem_be, dmem_addr} !==
            {1'b1, 1'b0, 4'b1111, {a[31:2], 2'b00}}) begin
            n_bad++;
            $display("FAIL ld_req %s: req%b we%b be%b a%h", op.name(),
                     dmem_req, dmem_we, dmem_be, dmem_addr);
        end
        for (int i = 0; i < gw; i++) begin
            n_cmp++;
            if ({dmem_req, ex_ready} !== 2'b10) begin
                n_bad++;
                $display("FAIL ld_gnt_wait %s: req%b rdy%b want 1 0",
                         op.name(), dmem_req, ex_ready);
            end
            tick();
        end
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        for (int i = 0; i < rw; i++) begin
            n_cmp++;
            if ({dmem_req, ex_ready, wb_valid} !== 3'b000) begin
                n_bad++;
                $display("FAIL ld_rv_wait %s: req%b rdy%b v%b want 0 0 0",
                         op.name(), dmem_req, ex_ready, wb_valid);
            end
            tick();
        end
        dmem_rvalid = 1'b1;
        dmem_rdata  = rd_word;
        tick();
        dmem_rvalid = 1'b0;
        n_cmp++;
        if ({wb_valid, wb_we, wb_rd, wb_data, ex_ready} !==
            {1'b1, 1'b1, 5'd7, exp, 1'b1}) begin
            n_bad++;
            $display("FAIL ld_wb %s: v%b we%b rd%0d d%h rdy%b want d%h",
                     op.name(), wb_valid, wb_we, wb_rd, wb_data, ex_ready, exp);
        end
    endtask

    task automatic test_misaligned();
        issue(MEM_LW, 32'h101, 32'h0, 5'd3);
        tick();
        ex_valid = 1'b0;
        n_cmp++;
        if ({misaligned, wb_valid, wb_we, dmem_req, ex_ready} !== 5'b11001) begin
            n_bad++;
            $display("FAIL lw_mis: mis%b v%b we%b req%b rdy%b want 1 1 0 0 1",
                     misaligned, wb_valid, wb_we, dmem_req, ex_ready);
        end
        tick();
        n_cmp++;
        if ({misaligned, wb_valid, dmem_req} !== 3'b000) begin
            n_bad++;
            $display("FAIL lw_mis_pulse: mis%b v%b req%b want 0 0 0",
                     misaligned, wb_valid, dmem_req);
        end
        issue(MEM_SH, 32'h103, 32'h0, 5'd0);
        tick();
        ex_valid = 1'b0;
        n_cmp++;
        if ({misaligned, wb_valid, dmem_req} !== 3'b110) begin
            n_bad++;
            $display("FAIL sh_mis: mis%b v%b req%b want 1 1 0",
                     misaligned, wb_valid, dmem_req);
        end
        issue(MEM_LH, 32'h102, 32'h0, 5'd3);
        tick();
        ex_valid = 1'b0;
        n_cmp++;
        if ({misaligned, wb_valid, dmem_req} !== 3'b001) begin
            n_bad++;
            $display("FAIL lh_ok: mis%b v%b req%b want 0 0 1",
                     misaligned, wb_valid, dmem_req);
        end
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'h7FFF0000;
        tick();
        dmem_rvalid = 1'b0;
        n_cmp++;
        if ({wb_valid, misaligned, wb_data} !== {1'b1, 1'b0, 32'h00007FFF}) begin
            n_bad++;
            $display("FAIL lh_ok_wb: v%b mis%b d%h want 1 0 00007FFF",
                     wb_valid, misaligned, wb_data);
        end
    endtask

    task automatic test_flush();
        issue(MEM_NONE, 32'h99, 32'h0, 5'd4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        ex_valid = 1'b0;
        n_cmp++;
        if ({wb_valid, dmem_req} !== 2'b00) begin
            n_bad++;
            $display("FAIL flush_idle: v%b req%b want 0 0", wb_valid, dmem_req);
        end
        issue(MEM_SW, 32'h300, 32'h1, 5'd0);
        tick();
        ex_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++;
        if ({dmem_req, wb_valid, ex_ready} !== 3'b001) begin
            n_bad++;
            $display("FAIL flush_req: req%b v%b rdy%b want 0 0 1",
                     dmem_req, wb_valid, ex_ready);
        end
        issue(MEM_SW, 32'h304, 32'h2, 5'd0);
        tick();
        ex_valid = 1'b0;
        flush = 1'b1;
        dmem_gnt = 1'b1;
        tick();
        flush = 1'b0;
        dmem_gnt = 1'b0;
        n_cmp++;
        if ({dmem_req, wb_valid, ex_ready} !== 3'b001) begin
            n_bad++;
            $display("FAIL flush_st_gnt: req%b v%b rdy%b want 0 0 1",
                     dmem_req, wb_valid, ex_ready);
        end
        issue(MEM_LW, 32'h100, 32'h0, 5'd9);
        tick();
        ex_valid = 1'b0;
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({wb_valid, ex_ready} !== 2'b00) begin
                n_bad++;
                $display("FAIL drain_wait: v%b rdy%b want 0 0", wb_valid, ex_ready);
            end
            tick();
        end
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        tick();
        dmem_rvalid = 1'b0;
        n_cmp++;
        if ({wb_valid, ex_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL drain_end: v%b rdy%b want 0 1", wb_valid, ex_ready);
        end
        issue(MEM_NONE, 32'hCAFE, 32'h0, 5'd4);
        tick();
        ex_valid = 1'b0;
        n_cmp++;
        if ({wb_valid, wb_we, wb_rd, wb_data} !==
            {1'b1, 1'b1, 5'd4, 32'h0000CAFE}) begin
            n_bad++;
            $display("FAIL after_drain: v%b we%b rd%0d d%h want 1 1 4 0000CAFE",
                     wb_valid, wb_we, wb_rd, wb_data);
        end
    endtask

    task automatic test_reset_mid();
        issue(MEM_SW, 32'h200, 32'h12345678, 5'd0);
        tick();
        ex_valid = 1'b0;
        n_cmp++;
        if (dmem_req !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_pre: req%b want 1", dmem_req);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
             wb_valid, wb_we, wb_rd, wb_data, misaligned, ex_ready} !==
            {2'b00, 32'h0, 4'h0, 32'h0, 2'b00, 5'd0, 32'h0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL rst_mid: req%b we%b a%h be%b wd%h v%b rdy%b",
                     dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                     wb_valid, ex_ready);
        end
        tick();
        rst_n = 1'b1;
        tick();
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'hFFFFFFFF;
        tick();
        dmem_rvalid = 1'b0;
        n_cmp++;
        if ({wb_valid, dmem_req, ex_ready} !== 3'b001) begin
            n_bad++;
            $display("FAIL stray_rvalid: v%b req%b rdy%b want 0 0 1",
                     wb_valid, dmem_req, ex_ready);
        end
    endtask

    initial begin
        test_reset();
        test_none();
        test_store();
        test_load(MEM_LB,  32'h102, 32'h00800000, 32'hFFFFFF80, 2, 3);
        test_load(MEM_LBU, 32'h102, 32'h00800000, 32'h00000080, 2, 3);
        test_load(MEM_LH,  32'h102, 32'h80010000, 32'hFFFF8001, 0, 0);
        test_load(MEM_LHU, 32'h102, 32'h80010000, 32'h00008001, 1, 1);
        test_load(MEM_LW,  32'h100, 32'h12345678, 32'h12345678, 0, 0);
        test_misaligned();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
